ps2_key_event_queue: RTL
========================

Name: ps2_key_event_queue

Overview:
- Parametrised successor to the fixed scancode-to-character case mapping at the top level.
- Consumes raw PS/2 bytes from the keyboard controller and parses make/break and extended (E0) prefix sequences into key events.
- Queues events in a FIFO for the processor and exposes per-key held/hit state for a configurable set of mapped game keys (e.g. arrows for Tetris control).
- Sits between PS2_Interface and the processor/VGA logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
NUM_KEYS, 4, number of mapped keys tracked in key_held/key_hit
KEYMAP, {9'h174,9'h16B,9'h172,9'h175}, packed NUM_KEYS x 9 bits; entry i = KEYMAP[i*9 +: 9] = {ext, scancode}; default key0=up(E0 75), key1=down(E0 72), key2=left(E0 6B), key3=right(E0 74)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
scan_valid  input  1  one-cycle strobe: scan_byte holds a newly received byte
scan_byte  input  8  received PS/2 byte
evt_valid  output  1  FIFO non-empty; evt_data valid
evt_data  output  10  head event {brk, ext, scancode[7:0]}
evt_ready  input  1  consumer pops the head when evt_valid && evt_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky: an event was dropped because the FIFO was full
clr_overflow  input  1  clears overflow
key_held  output  NUM_KEYS  level: mapped key currently pressed
key_hit  output  NUM_KEYS  one-cycle pulse on an accepted make of a mapped key

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset is synchronous and active-high.
  - On reset: parser goes to IDLE; FIFO is emptied (pointers 0, fifo_count=0, evt_valid=0).
  - Also on reset: evt_data=0, overflow=0, key_held=0, key_hit=0.
  - Reset mid-sequence discards any partial prefix.
- Parser FSM (advances only on scan_valid):
  - States: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; E1 -> IDLE (pause sequence ignored); any other byte b completes event {0,0,b} -> IDLE.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> GOT_E0; E1 -> IDLE, no event; other b completes {0,1,b} -> IDLE.
  - GOT_F0: E0/F0/E1 -> IDLE, no event (malformed); other b completes {1,0,b} -> IDLE.
  - GOT_E0F0: E0/F0/E1 -> IDLE, no event; other b completes {1,1,b} -> IDLE.
- Event completion on cycle N (the scan_valid cycle):
  - Push to FIFO, visible as evt_valid/evt_data at N+1.
  - Key match: for every i with KEYMAP[i] == {ext,b}, update key_held[i] at N+1 (make sets, break clears).
  - On make, key_hit[i]=1 for cycle N+1 only.
  - Multiple identical KEYMAP entries all respond.
  - Break of a key not held: key_held unchanged at 0; event still queued.
  - key_held/key_hit update even when the FIFO push is dropped.
- FIFO:
  - First-word fall-through: evt_data = head entry whenever evt_valid=1. evt_data is don't-care when empty.
  - Pop only when evt_valid && evt_ready; evt_ready while empty is ignored.
  - Push+pop in the same cycle when full: both occur, count unchanged.
  - Push+pop when empty is impossible, since a push becomes visible next cycle.
  - Push when full without pop: event dropped, overflow set at N+1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- overflow:
  - Cleared by clr_overflow the cycle after it is asserted.
  - Same-cycle set and clear: set wins.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A make event whose {ext,b} matches a mapped key with key_held[i]=1 (auto-repeat) is not pushed and produces no key_hit.
  - Unmapped keys are always queued.
  - Breaks are always queued.
- Undefined: every make event is pushed and pulses key_hit, including auto-repeats.

Test Plan:
1. Bytes 1C -> one event 10'h01C at evt_valid; hold evt_ready=0; fifo_count=1; key_held=0.
2. Bytes E0 75, then E0 F0 75 -> events 10'h175, 10'h375 in order; key_held[0] goes 1 then 0; key_hit[0] pulses once, one cycle after the 75 byte.
3. Push FIFO_DEPTH+1 plain events (8'h10..8'h18) with evt_ready=0 -> fifo_count=8; overflow=1; drained data 010..017 (018 lost); clr_overflow -> overflow=0.
4. Full FIFO; pop and push in the same cycle -> fifo_count stays 8; new event appears last on drain.
5. Bytes E0 F0 then reset, then 6B -> event 10'h06B (no ext/brk); all outputs 0 during reset.
6. E0 6B sent three times (repeat) -> macro off: 3 events, 3 key_hit[2] pulses; macro on: 1 event, 1 pulse; key_held[2]=1 in both cases.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
// PS/2 byte parser with make/break and E0 handling, a first-word fall-through event FIFO
// and per-key held/hit tracking. Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeat makes of held mapped keys.
module ps2_key_event_queue #(
    parameter int                      FIFO_DEPTH = 8,
    parameter int                      NUM_KEYS   = 4,
    parameter logic [NUM_KEYS*9-1:0]   KEYMAP     = {9'h174, 9'h16B, 9'h172, 9'h175}
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_byte,
    output logic                          evt_valid,
    output logic [9:0]                    evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [NUM_KEYS-1:0]           key_held,
    output logic [NUM_KEYS-1:0]           key_hit
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } state_t;

    state_t              state_q;
    logic [9:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [NUM_KEYS-1:0] key_held_q, key_held_d;
    logic [NUM_KEYS-1:0] key_hit_q, key_hit_d;

    logic                is_prefix_s;
    logic                evt_done_s;
    logic [9:0]          evt_word_s;
    logic [NUM_KEYS-1:0] match_s;
    logic                is_make_s;
    logic                repeat_s;
    logic                push_req_s;
    logic                push_ok_s;
    logic                pop_s;
    logic                full_s;

    // Byte classification and event assembly for the current parser state
    always_comb begin
        is_prefix_s = (scan_byte == 8'hE0) || (scan_byte == 8'hF0) || (scan_byte == 8'hE1);
        evt_done_s  = 1'b0;
        evt_word_s  = {2'b00, scan_byte};
        if (scan_valid && !is_prefix_s) begin
            evt_done_s = 1'b1;
            case (state_q)
                ST_IDLE:     evt_word_s = {2'b00, scan_byte};
                ST_GOT_E0:   evt_word_s = {2'b01, scan_byte};
                ST_GOT_F0:   evt_word_s = {2'b10, scan_byte};
                ST_GOT_E0F0: evt_word_s = {2'b11, scan_byte};
                default:     evt_word_s = {2'b00, scan_byte};
            endcase
        end else begin
            evt_done_s = 1'b0;
        end
    end

    // Parser state machine; only prefix bytes move it away from IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_byte == 8'hE0)      state_q <= ST_GOT_E0;
                    else if (scan_byte == 8'hF0) state_q <= ST_GOT_F0;
                    else                         state_q <= ST_IDLE;
                end
                ST_GOT_E0: begin
                    if (scan_byte == 8'hF0)      state_q <= ST_GOT_E0F0;
                    else if (scan_byte == 8'hE0) state_q <= ST_GOT_E0;
                    else                         state_q <= ST_IDLE;
                end
                ST_GOT_F0:   state_q <= ST_IDLE;
                ST_GOT_E0F0: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    // Mapped key matching, auto-repeat detection and key state next values
    always_comb begin
        is_make_s = ~evt_word_s[9];
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_s[i] = evt_done_s && (KEYMAP[i*9 +: 9] == evt_word_s[8:0]);
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        repeat_s = is_make_s && (|(match_s & key_held_q));
`else
        repeat_s = 1'b0;
`endif
        key_held_d = (key_held_q & ~match_s) | (match_s & {NUM_KEYS{is_make_s}});
        key_hit_d  = match_s & {NUM_KEYS{is_make_s && !repeat_s}};
    end

    // FIFO control: a pop frees the slot a same-cycle push needs when full
    always_comb begin
        full_s     = (count_q == CW'(FIFO_DEPTH));
        pop_s      = (count_q != {CW{1'b0}}) && evt_ready;
        push_req_s = evt_done_s && !repeat_s;
        push_ok_s  = push_req_s && (!full_s || pop_s);
        wr_ptr_d   = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req_s && !push_ok_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= evt_word_s;
        end
    end

    // Pointer, occupancy, overflow and key state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
            key_held_q <= {NUM_KEYS{1'b0}};
            key_hit_q  <= {NUM_KEYS{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            key_held_q <= key_held_d;
            key_hit_q  <= key_hit_d;
        end
    end

    assign evt_valid  = (count_q != {CW{1'b0}});
    assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : 10'h000;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign key_held   = key_held_q;
    assign key_hit    = key_hit_q;

endmodule
